// File: rtl/sram_model.sv
// Behavioural single-port SRAM used as external memory in system simulation:
// synchronous write, combinational or one-cycle registered read on a shared tristate bus.
module sram_model #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 18,
    parameter int unsigned DEPTH        = 262144,
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]      addr_idx_c;
    logic                  wr_fire_c;
    logic                  rd_cyc_c;
    logic                  drive_en_c;
    logic [DATA_WIDTH-1:0] rd_data_c;

    // Upper address bits alias onto the stored range when DEPTH is smaller.
    generate
        if (IDX_W < ADDR_WIDTH) begin : g_alias
            logic unused_addr_c;
            assign unused_addr_c = ^addr[ADDR_WIDTH-1:IDX_W];
        end
    endgenerate

    // Cycle decode; an unknown strobe falls through to neither write nor read.
    always_comb begin
        addr_idx_c = addr[IDX_W-1:0];
        wr_fire_c  = 1'b0;
        rd_cyc_c   = 1'b0;
        if (rst && !write_en) begin
            wr_fire_c = 1'b1;
        end
        if (rst && write_en) begin
            rd_cyc_c = 1'b1;
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            mem_q[addr_idx_c] <= data;
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_async_rd
            always_comb begin
                drive_en_c = rd_cyc_c;
                rd_data_c  = mem_q[addr_idx_c];
            end
        end else begin : g_sync_rd
            logic [DATA_WIDTH-1:0] rd_reg_q;
            logic [DATA_WIDTH-1:0] rd_reg_d;
            logic                  rd_valid_q;
            logic                  rd_valid_d;

            // A write edge invalidates the read pipe so stale data is never driven.
            always_comb begin
                rd_reg_d   = rd_reg_q;
                rd_valid_d = 1'b0;
                if (rd_cyc_c) begin
                    rd_reg_d   = mem_q[addr_idx_c];
                    rd_valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rd_reg_q   <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_reg_q   <= rd_reg_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            always_comb begin
                drive_en_c = rd_cyc_c && rd_valid_q;
                rd_data_c  = rd_reg_q;
            end
        end
    endgenerate

    // Enable follows write_en combinationally so the bus is released without a contention cycle.
    assign data = drive_en_c ? rd_data_c : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_model.sv
// Directed bench for sram_model: latency-0, latency-1 and 1024-deep aliasing instances
// share control inputs; released buses are pulled high so 16'hFFFF marks an undriven bus.
module tb_sram_model;

    logic        clk;
    logic        rst;
    logic        write_en;
    logic [17:0] addr;
    logic        tb_drv;
    logic [15:0] tb_val;

    tri1 [15:0] bus0;
    tri1 [15:0] bus1;
    tri1 [15:0] bus2;

    int checks;
    int failures;

    assign bus0 = tb_drv ? tb_val : 16'hzzzz;
    assign bus1 = tb_drv ? tb_val : 16'hzzzz;
    assign bus2 = tb_drv ? tb_val : 16'hzzzz;

    sram_model u_lat0 (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .addr     (addr),
        .data     (bus0)
    );

    sram_model #(.READ_LATENCY(1)) u_lat1 (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .addr     (addr),
        .data     (bus1)
    );

    sram_model #(.DEPTH(1024)) u_alias (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .addr     (addr),
        .data     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr_cycle(input logic [17:0] a, input logic [15:0] v);
        @(negedge clk);
        write_en = 1'b0;
        addr     = a;
        tb_drv   = 1'b1;
        tb_val   = v;
        @(posedge clk);
    endtask

    task automatic rd_set(input logic [17:0] a);
        @(negedge clk);
        write_en = 1'b1;
        tb_drv   = 1'b0;
        addr     = a;
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (bus0 !== 16'hFFFF) begin failures++; $display("FAIL reset_idle_lat0: got %h exp %h", bus0, 16'hFFFF); end
        checks++; if (bus1 !== 16'hFFFF) begin failures++; $display("FAIL reset_idle_lat1: got %h exp %h", bus1, 16'hFFFF); end
        @(negedge clk);
        rst = 1'b1;
        wr_cycle(18'h00000, 16'hBEEF);
        rd_set(18'h00000);
        checks++; if (bus0 !== 16'hBEEF) begin failures++; $display("FAIL reset_pre_read_lat0: got %h exp %h", bus0, 16'hBEEF); end
        checks++; if (bus1 !== 16'hFFFF) begin failures++; $display("FAIL reset_pre_read_lat1: got %h exp %h", bus1, 16'hFFFF); end
        @(posedge clk); #1;
        checks++; if (bus1 !== 16'hBEEF) begin failures++; $display("FAIL reset_pre_read_lat1_reg: got %h exp %h", bus1, 16'hBEEF); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus0 !== 16'hFFFF) begin failures++; $display("FAIL reset_midread_lat0: got %h exp %h", bus0, 16'hFFFF); end
        checks++; if (bus1 !== 16'hFFFF) begin failures++; $display("FAIL reset_midread_lat1: got %h exp %h", bus1, 16'hFFFF); end
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus0 !== 16'hBEEF) begin failures++; $display("FAIL reset_preserve_lat0: got %h exp %h", bus0, 16'hBEEF); end
        checks++; if (bus1 !== 16'hFFFF) begin failures++; $display("FAIL reset_valid_clear_lat1: got %h exp %h", bus1, 16'hFFFF); end
        @(posedge clk); #1;
        checks++; if (bus1 !== 16'hBEEF) begin failures++; $display("FAIL reset_preserve_lat1: got %h exp %h", bus1, 16'hBEEF); end
    endtask

    task automatic test_write_readback;
        wr_cycle(18'h00005, 16'h1234);
        wr_cycle(18'h3FFFF, 16'hA5A5);
        rd_set(18'h00005);
        checks++; if (bus0 !== 16'h1234) begin failures++; $display("FAIL rd5_lat0: got %h exp %h", bus0, 16'h1234); end
        checks++; if (bus1 !== 16'hFFFF) begin failures++; $display("FAIL rd5_lat1_before: got %h exp %h", bus1, 16'hFFFF); end
        rd_set(18'h3FFFF);
        checks++; if (bus0 !== 16'hA5A5) begin failures++; $display("FAIL rdtop_lat0: got %h exp %h", bus0, 16'hA5A5); end
        checks++; if (bus1 !== 16'h1234) begin failures++; $display("FAIL rd5_lat1: got %h exp %h", bus1, 16'h1234); end
        @(posedge clk); #1;
        checks++; if (bus1 !== 16'hA5A5) begin failures++; $display("FAIL rdtop_lat1: got %h exp %h", bus1, 16'hA5A5); end
    endtask

    task automatic test_bus_ownership;
        @(negedge clk);
        write_en = 1'b0;
        addr     = 18'h00005;
        tb_drv   = 1'b1;
        tb_val   = 16'h5555;
        #1;
        checks++; if (bus0 !== 16'h5555) begin failures++; $display("FAIL own_drive_lat0: got %h exp %h", bus0, 16'h5555); end
        checks++; if (bus1 !== 16'h5555) begin failures++; $display("FAIL own_drive_lat1: got %h exp %h", bus1, 16'h5555); end
        checks++; if (bus2 !== 16'h5555) begin failures++; $display("FAIL own_drive_alias: got %h exp %h", bus2, 16'h5555); end
        tb_drv = 1'b0;
        #1;
        checks++; if (bus0 !== 16'hFFFF) begin failures++; $display("FAIL own_release_lat0: got %h exp %h", bus0, 16'hFFFF); end
        checks++; if (bus1 !== 16'hFFFF) begin failures++; $display("FAIL own_release_lat1: got %h exp %h", bus1, 16'hFFFF); end
        checks++; if (bus2 !== 16'hFFFF) begin failures++; $display("FAIL own_release_alias: got %h exp %h", bus2, 16'hFFFF); end
        write_en = 1'b1;
        #1;
        checks++; if (bus0 !== 16'h1234) begin failures++; $display("FAIL own_turn_lat0: got %h exp %h", bus0, 16'h1234); end
        checks++; if (bus1 !== 16'hA5A5) begin failures++; $display("FAIL own_turn_lat1: got %h exp %h", bus1, 16'hA5A5); end
        checks++; if (bus2 !== 16'h1234) begin failures++; $display("FAIL own_turn_alias: got %h exp %h", bus2, 16'h1234); end
    endtask

    task automatic test_back_to_back;
        wr_cycle(18'h00007, 16'h0001);
        wr_cycle(18'h00007, 16'h0002);
        #1;
        write_en = 1'b1;
        tb_drv   = 1'b0;
        #1;
        checks++; if (bus0 !== 16'h0002) begin failures++; $display("FAIL b2b_lat0: got %h exp %h", bus0, 16'h0002); end
        checks++; if (bus1 !== 16'hFFFF) begin failures++; $display("FAIL b2b_lat1_before: got %h exp %h", bus1, 16'hFFFF); end
        @(posedge clk); #1;
        checks++; if (bus1 !== 16'h0002) begin failures++; $display("FAIL b2b_lat1: got %h exp %h", bus1, 16'h0002); end
    endtask

    task automatic test_aliasing;
        wr_cycle(18'h00003, 16'h0AAA);
        wr_cycle(18'h00403, 16'h00FF);
        rd_set(18'h00003);
        checks++; if (bus2 !== 16'h00FF) begin failures++; $display("FAIL alias_low_alias: got %h exp %h", bus2, 16'h00FF); end
        checks++; if (bus0 !== 16'h0AAA) begin failures++; $display("FAIL alias_low_full: got %h exp %h", bus0, 16'h0AAA); end
        rd_set(18'h00403);
        checks++; if (bus2 !== 16'h00FF) begin failures++; $display("FAIL alias_high_alias: got %h exp %h", bus2, 16'h00FF); end
        checks++; if (bus0 !== 16'h00FF) begin failures++; $display("FAIL alias_high_full: got %h exp %h", bus0, 16'h00FF); end
    endtask

    task automatic test_write_under_reset;
        wr_cycle(18'h00009, 16'h1111);
        @(negedge clk);
        rst      = 1'b0;
        write_en = 1'b0;
        addr     = 18'h00009;
        tb_drv   = 1'b1;
        tb_val   = 16'hDEAD;
        @(posedge clk);
        @(negedge clk);
        tb_drv   = 1'b0;
        write_en = 1'b1;
        rst      = 1'b1;
        #1;
        checks++; if (bus0 !== 16'h1111) begin failures++; $display("FAIL wur_lat0: got %h exp %h", bus0, 16'h1111); end
        checks++; if (bus2 !== 16'h1111) begin failures++; $display("FAIL wur_alias: got %h exp %h", bus2, 16'h1111); end
        checks++; if (bus1 !== 16'hFFFF) begin failures++; $display("FAIL wur_lat1_before: got %h exp %h", bus1, 16'hFFFF); end
        @(posedge clk); #1;
        checks++; if (bus1 !== 16'h1111) begin failures++; $display("FAIL wur_lat1: got %h exp %h", bus1, 16'h1111); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        write_en = 1'b1;
        addr     = '0;
        tb_drv   = 1'b0;
        tb_val   = '0;
        test_reset();
        test_write_readback();
        test_bus_ownership();
        test_back_to_back();
        test_aliasing();
        test_write_under_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
